pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the monocycle core. It is the successor to the fixed PC+4 adder: it owns the PC register and selects the next PC from sequential, branch or jalr sources. It adds stall, halt/resume, boot sequencing and misaligned-target trapping. It sits between the branch/jump resolution logic and instruction memory.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target trap
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, number of low PC bits that must be zero (1 = compressed-capable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC this cycle
pc_src  in  2  next-PC select: 00 SEQ, 01 BRANCH, 10 JALR, 11 reserved (treated as SEQ)
branch_taken  in  1  qualifies pc_src=BRANCH
branch_target  in  XLEN  branch destination address
jalr_target  in  XLEN  raw jalr sum; bit 0 is cleared internally
halt  in  1  request halt
resume  in  1  leave HALT state
pc  out  XLEN  current PC (registered)
pc_next_seq  out  XLEN  pc + INC, combinational, modulo 2^XLEN
pc_valid  out  1  pc is a live fetch address
misaligned  out  1  one-cycle pulse, asserted the cycle after the trapping redirect
fault_addr  out  XLEN  last offending target (registered)
state  out  2  BOOT=0, RUN=1, HALT=2

Behaviour:
- Reset (sync, rst=1 at clock edge): pc=RESET_VECTOR, state=BOOT, pc_valid=0, misaligned=0, fault_addr=0. Reset overrides every other input, including reset asserted mid-halt or mid-stall.
- BOOT: on the first edge with rst=0, go to RUN; pc stays RESET_VECTOR; pc_valid=1 from then on. Other inputs are ignored in BOOT.
- RUN next-PC priority (highest first): halt > stall > redirect > sequential.
  - halt=1: go to HALT; pc held.
  - stall=1: pc held. Any redirect in the same cycle is dropped; the requester must hold it until stall=0.
  - pc_src=BRANCH and branch_taken=1: candidate = branch_target.
  - pc_src=BRANCH and branch_taken=0: candidate = pc+INC.
  - pc_src=JALR: candidate = {jalr_target[XLEN-1:1],1'b0}.
  - Otherwise: candidate = pc+INC.
- Misaligned check applies to redirect candidates only. If candidate[ALIGN_BITS-1:0]!=0:
  - pc <= TRAP_VECTOR and fault_addr <= candidate.
  - misaligned=1 for exactly the next cycle.
- Sequential increment is never checked; an aligned PC stays aligned when INC is a multiple of 2^ALIGN_BITS.
- Arithmetic: all addition is unsigned modulo 2^XLEN. Example: 32'hFFFF_FFFC+4 = 0, with no flag.
- HALT: pc held; pc_valid=0.
  - resume=1 and halt=0: go to RUN next edge; pc_valid=1; fetch continues at the held pc.
  - halt and resume both 1: remain in HALT.
  - stall and redirect inputs are ignored in HALT.
- Latency: a selected next PC appears on pc one clock after the selecting edge. pc_next_seq has zero latency.
- misaligned is 0 in every cycle not directly following a trapping redirect.
- Back-to-back traps each produce their own pulse and update fault_addr.

Decomposition:
- Package pc_pkg:
  - pc_src_e enum (SEQ, BRANCH, JALR, RSVD).
  - pc_state_e enum (BOOT, RUN, HALT).
  - Default vector constants.
- Sub-module pc_incrementer (param XLEN, INC): combinational pc + INC with wrap. It is the generalised successor of the existing adder, instantiated once for pc_next_seq.
- State machine and PC register live in pc_unit.

Test Plan:
- Reset then release, defaults → pc=0 and pc_valid=0 in BOOT; next cycle state=RUN, pc_valid=1; then pc steps 0x0, 0x4, 0x8, 0xC on successive cycles with pc_src=SEQ.
- Force pc=0xFFFF_FFF8, SEQ for 2 cycles → pc 0xFFFF_FFFC then 0x0000_0000; no misaligned pulse.
- pc_src=BRANCH, branch_taken=1, target 0x0000_1000 → pc=0x1000 next cycle. Same with branch_taken=0 at pc 0x20 → pc=0x24.
- pc_src=JALR, jalr_target=0x0000_2003, ALIGN_BITS=2 → bit 0 cleared gives 0x2002, which is misaligned. Result: pc=0x100, fault_addr=0x2002, misaligned=1 for one cycle. With ALIGN_BITS=1 the same input gives pc=0x2002 and no trap.
- stall=1 with a simultaneous BRANCH to 0x500 at pc 0x40 → pc stays 0x40. Release stall while still presenting the branch → pc=0x500.
- halt=1 at pc 0x80 → state=HALT, pc_valid=0, pc holds 0x80. halt+resume together → still HALT. resume alone → RUN, pc then 0x80, 0x84. rst=1 while halted → pc=RESET_VECTOR and state=BOOT next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;

   typedef enum logic [1:0] {
      SEQ    = 2'b00,
      BRANCH = 2'b01,
      JALR   = 2'b10,
      RSVD   = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam int unsigned DEF_XLEN         = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
   localparam int unsigned DEF_INC          = 4;
   localparam int unsigned DEF_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational sequential-address adder: sum = pc + INC, wrapping modulo 2^XLEN.
module pc_incrementer #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned INC  = 4
) (
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] sum
);

   assign sum = pc + XLEN'(INC);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: owns the PC register, selects sequential/branch/jalr next PC,
// and handles boot, stall, halt/resume and misaligned-target trapping.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
   parameter int unsigned     INC          = DEF_INC,
   parameter int unsigned     ALIGN_BITS   = DEF_ALIGN_BITS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [1:0]      pc_src,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   input  logic            halt,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next_seq,
   output logic            pc_valid,
   output logic            misaligned,
   output logic [XLEN-1:0] fault_addr,
   output logic [1:0]      state
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [XLEN-1:0] JALR_MASK  = ~XLEN'(1);

   pc_state_e       state_q;
   logic            redirect;
   logic            target_bad;
   logic [XLEN-1:0] candidate;

   pc_incrementer #(
      .XLEN (XLEN),
      .INC  (INC)
   ) u_inc (
      .pc  (pc),
      .sum (pc_next_seq)
   );

   // Redirect selection; sequential flow never goes through the alignment check.
   always_comb begin
      redirect  = 1'b0;
      candidate = pc_next_seq;
      unique case (pc_src_e'(pc_src))
         BRANCH: begin
            if (branch_taken) begin
               redirect  = 1'b1;
               candidate = branch_target;
            end
         end
         JALR: begin
            redirect  = 1'b1;
            candidate = jalr_target & JALR_MASK;
         end
         default: begin
            redirect  = 1'b0;
            candidate = pc_next_seq;
         end
      endcase
      target_bad = redirect && ((candidate & ALIGN_MASK) != '0);
   end

   // State machine and PC register; priority in RUN is halt > stall > redirect > sequential.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         pc         <= RESET_VECTOR;
         pc_valid   <= 1'b0;
         misaligned <= 1'b0;
         fault_addr <= '0;
      end else begin
         misaligned <= 1'b0;
         case (state_q)
            BOOT: begin
               state_q  <= RUN;
               pc_valid <= 1'b1;
            end
            RUN: begin
               if (halt) begin
                  state_q  <= HALT;
                  pc_valid <= 1'b0;
               end else if (stall) begin
                  pc <= pc;
               end else if (target_bad) begin
                  pc         <= TRAP_VECTOR;
                  fault_addr <= candidate;
                  misaligned <= 1'b1;
               end else begin
                  pc <= candidate;
               end
            end
            HALT: begin
               if (resume && !halt) begin
                  state_q  <= RUN;
                  pc_valid <= 1'b1;
               end
            end
            default: begin
               state_q  <= BOOT;
               pc_valid <= 1'b0;
            end
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one instance with ALIGN_BITS=2 and one with ALIGN_BITS=1 on shared inputs.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  pc_src;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;
   logic        halt;
   logic        resume;

   logic [31:0] pc,  pc_next_seq,  fault_addr;
   logic        pc_valid,  misaligned;
   logic [1:0]  state;
   logic [31:0] pc1, pc_next_seq1, fault_addr1;
   logic        pc_valid1, misaligned1;
   logic [1:0]  state1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_unit u_dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .pc_src        (pc_src),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .halt          (halt),
      .resume        (resume),
      .pc            (pc),
      .pc_next_seq   (pc_next_seq),
      .pc_valid      (pc_valid),
      .misaligned    (misaligned),
      .fault_addr    (fault_addr),
      .state         (state)
   );

   pc_unit #(.ALIGN_BITS(1)) u_dut1 (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .pc_src        (pc_src),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .halt          (halt),
      .resume        (resume),
      .pc            (pc1),
      .pc_next_seq   (pc_next_seq1),
      .pc_valid      (pc_valid1),
      .misaligned    (misaligned1),
      .fault_addr    (fault_addr1),
      .state         (state1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; pc_src = 2'b00; branch_taken = 1'b0;
      branch_target = '0; jalr_target = '0; halt = 1'b0; resume = 1'b0;
      step(); step();
      check("rst_pc", pc, 32'h0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_valid", 32'(pc_valid), 32'd0);
      check("rst_mis", 32'(misaligned), 32'd0);
      check("rst_fault", fault_addr, 32'h0);

      // Leave reset; a branch presented during BOOT must be ignored.
      rst = 1'b0; pc_src = 2'b01; branch_taken = 1'b1; branch_target = 32'h0000_0777;
      step();
      check("boot_state", 32'(state), 32'd1);
      check("boot_valid", 32'(pc_valid), 32'd1);
      check("boot_pc", pc, 32'h0);
      pc_src = 2'b00; branch_taken = 1'b0;
      check("seq_next_comb", pc_next_seq, 32'h4);
      step(); check("seq_pc4", pc, 32'h4);
      step(); check("seq_pc8", pc, 32'h8);
      step(); check("seq_pcC", pc, 32'hC);
      check("seq_next_10", pc_next_seq, 32'h10);

      // Wrap-around of the sequential adder.
      pc_src = 2'b01; branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
      step(); check("br_high", pc, 32'hFFFF_FFF8);
      pc_src = 2'b00; branch_taken = 1'b0;
      step(); check("wrap_pcFC", pc, 32'hFFFF_FFFC);
      check("wrap_next", pc_next_seq, 32'h0);
      step(); check("wrap_pc0", pc, 32'h0);
      check("wrap_nomis", 32'(misaligned), 32'd0);

      // Taken and not-taken branches.
      pc_src = 2'b01; branch_taken = 1'b1; branch_target = 32'h0000_1000;
      step(); check("br_taken", pc, 32'h1000);
      branch_target = 32'h0000_0020;
      step(); check("br_to20", pc, 32'h20);
      branch_taken = 1'b0;
      step(); check("br_not_taken", pc, 32'h24);
      check("br_not_taken_a1", pc1, 32'h24);

      // jalr to 0x2003 -> 0x2002: trap with ALIGN_BITS=2, legal with ALIGN_BITS=1.
      pc_src = 2'b10; jalr_target = 32'h0000_2003;
      step();
      check("jalr_trap_pc", pc, 32'h100);
      check("jalr_fault", fault_addr, 32'h2002);
      check("jalr_mis", 32'(misaligned), 32'd1);
      check("jalr_a1_pc", pc1, 32'h2002);
      check("jalr_a1_mis", 32'(misaligned1), 32'd0);
      check("jalr_a1_fault", fault_addr1, 32'h0);
      pc_src = 2'b00;
      step();
      check("jalr_mis_drop", 32'(misaligned), 32'd0);
      check("trap_seq", pc, 32'h104);
      check("jalr_a1_seq", pc1, 32'h2006);

      // Back-to-back traps.
      pc_src = 2'b10; jalr_target = 32'h0000_2003;
      step();
      check("b2b_mis1", 32'(misaligned), 32'd1);
      check("b2b_fault1", fault_addr, 32'h2002);
      pc_src = 2'b01; branch_taken = 1'b1; branch_target = 32'h0000_3006;
      step();
      check("b2b_mis2", 32'(misaligned), 32'd1);
      check("b2b_fault2", fault_addr, 32'h3006);
      check("b2b_pc", pc, 32'h100);
      check("b2b_a1_pc", pc1, 32'h3006);

      // Stall drops a simultaneous redirect until released.
      branch_target = 32'h0000_0040;
      step(); check("to40", pc, 32'h40);
      check("to40_mis", 32'(misaligned), 32'd0);
      stall = 1'b1; branch_target = 32'h0000_0500;
      step(); check("stall_hold1", pc, 32'h40);
      step(); check("stall_hold2", pc, 32'h40);
      stall = 1'b0;
      step(); check("stall_release", pc, 32'h500);

      // Halt / resume.
      branch_target = 32'h0000_0080;
      step(); check("to80", pc, 32'h80);
      pc_src = 2'b00; branch_taken = 1'b0; halt = 1'b1;
      step();
      check("halt_state", 32'(state), 32'd2);
      check("halt_valid", 32'(pc_valid), 32'd0);
      check("halt_pc", pc, 32'h80);
      resume = 1'b1; stall = 1'b1; pc_src = 2'b01; branch_taken = 1'b1; branch_target = 32'h0000_0900;
      step();
      check("halt_res_state", 32'(state), 32'd2);
      check("halt_res_pc", pc, 32'h80);
      halt = 1'b0; stall = 1'b0; pc_src = 2'b00; branch_taken = 1'b0;
      step();
      check("resume_state", 32'(state), 32'd1);
      check("resume_valid", 32'(pc_valid), 32'd1);
      check("resume_pc", pc, 32'h80);
      resume = 1'b0;
      step(); check("resume_seq", pc, 32'h84);

      // Reset while halted.
      halt = 1'b1;
      step(); check("halt2_state", 32'(state), 32'd2);
      rst = 1'b1;
      step();
      check("rst_halt_pc", pc, 32'h0);
      check("rst_halt_state", 32'(state), 32'd0);
      check("rst_halt_valid", 32'(pc_valid), 32'd0);
      check("rst_halt_fault", fault_addr, 32'h0);
      rst = 1'b0; halt = 1'b0;
      step();
      check("rerun_state", 32'(state), 32'd1);
      step(); check("rerun_pc", pc, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
